// File: rtl/simon_io_pkg.sv
// Shared types and constants for the Simon 32/64 serial pad-side front end.
package simon_io_pkg;

  localparam int SIMON_BLK_W = 32;
  localparam int SIMON_KEY_W = 64;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } io_state_e;

  // Input beats per frame: whole key followed by whole plaintext.
  function automatic int calc_nb(input int dw);
    return (SIMON_KEY_W + SIMON_BLK_W) / dw;
  endfunction

endpackage

// File: rtl/simon_serial_io.sv
// Narrow-bus wrapper around simon_for: deserialises key+plaintext, waits the
// core latency, then streams the ciphertext out LSB beat first.
module simon_serial_io
  import simon_io_pkg::*;
#(
  parameter int DW       = 8,
  parameter int CORE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIMON_BLK_W-1:0] plaintext,
  output logic [SIMON_KEY_W-1:0] keytext,
  input  logic [SIMON_BLK_W-1:0] ciphertext,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int NB  = calc_nb(DW);
  localparam int NBK = SIMON_KEY_W / DW;
  localparam int NBO = SIMON_BLK_W / DW;
  localparam int BCW = $clog2(NB);
  localparam int WCW = $clog2(CORE_LAT + 1) + 1;

  generate
    if (SIMON_BLK_W % DW != 0) begin : g_dw_chk
      $error("simon_serial_io: DW must divide 32");
    end
  endgenerate

  io_state_e              state, state_nxt;
  logic [BCW-1:0]         beat_cnt;
  logic [WCW-1:0]         wait_cnt;
  logic [SIMON_BLK_W-1:0] sreg;
  logic                   in_acc, out_acc;
  logic                   last_in, last_out, wait_done;

  assign last_in   = (beat_cnt == BCW'(NB - 1));
  assign last_out  = (beat_cnt == BCW'(NBO - 1));
  assign wait_done = (wait_cnt == WCW'(CORE_LAT));
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign out_data  = sreg[DW-1:0];
  assign busy      = (state != LOAD);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_in) state_nxt = WAIT;
      end
      WAIT: if (wait_done) state_nxt = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && last_out) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      plaintext  <= '0;
      keytext    <= '0;
      sreg       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;
      unique case (state)
        LOAD: if (in_acc) begin
          // Beat index selects the slice: key words first, then plaintext.
          for (int k = 0; k < NBK; k++)
            if (beat_cnt == BCW'(k)) keytext[k*DW +: DW] <= in_data;
          for (int k = 0; k < NBO; k++)
            if (beat_cnt == BCW'(NBK + k)) plaintext[k*DW +: DW] <= in_data;
          beat_cnt <= last_in ? '0 : beat_cnt + 1'b1;
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
          if (wait_done) sreg <= ciphertext;
        end
        SEND: if (out_acc) begin
          sreg       <= sreg >> DW;
          beat_cnt   <= last_out ? '0 : beat_cnt + 1'b1;
          frame_done <= last_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/simon_serial_io.md
Name: simon_serial_io

Overview:
- Narrow-bus front/back end for the Simon 32/64 encryption core (simon_for); sits between the chip I/O pads and the core.
- Cuts the 97 input and 32 output pad cells to about 2×DW+5.
- Deserialises a 64-bit key plus a 32-bit plaintext from DW-bit beats and drives them to the core; waits the core latency, captures the ciphertext, then serialises it out with a valid/ready handshake.

Parameters:
- DW, 8: serial beat width in bits. Must divide 32; values 1, 2, 4, 8, 16 are legal.
- CORE_LAT, 1: clock cycles from keytext/plaintext stable until the core's ciphertext is valid. 0 means a combinational core.

Ports:
- clk  in  1  : system clock.
- rst  in  1  : synchronous, active-high reset.
- in_data  in  DW  : input beat.
- in_valid  in  1  : input beat valid.
- in_ready  out  1  : block accepts an input beat.
- out_data  out  DW  : ciphertext beat.
- out_valid  out  1  : out_data valid.
- out_ready  in  1  : downstream accepts the beat.
- plaintext  out  32  : to core plaintext.
- keytext  out  64  : to core keytext.
- ciphertext  in  32  : from core ciphertext.
- busy  out  1  : high in any state other than LOAD.
- frame_done  out  1  : one-cycle pulse when the last ciphertext beat is accepted.

Behaviour:
- One clock: clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state=LOAD, beat_cnt=0, wait_cnt=0, plaintext=0, keytext=0, shift-out register=0, in_ready=1, out_valid=0, out_data=0, busy=0, frame_done=0.
- FSM states: LOAD, WAIT, SEND.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Beats 0..(64/DW-1) fill keytext, least significant beat first: beat k writes keytext[k*DW +: DW].
  - The next 32/DW beats fill plaintext, least significant first.
  - Total beats NB = 96/DW (12 at DW=8). beat_cnt increments only on accept.
  - On acceptance of beat NB-1: beat_cnt←0, wait_cnt←0, go to WAIT.
  - Without in_valid the state holds indefinitely; no timeout.
- plaintext and keytext are registers written only on accepted beats. They hold through WAIT and SEND. Partial values reaching the core during LOAD are harmless.
- WAIT:
  - Lasts exactly CORE_LAT+1 cycles; in_ready=0, out_valid=0.
  - On the clock edge ending the last WAIT cycle: shift-out register←ciphertext, go to SEND.
- SEND:
  - out_valid=1; out_data = shift-out register[DW-1:0], so the least significant beat goes first.
  - On out_valid && out_ready: shift right by DW, beat_cnt++.
  - While out_ready=0, out_data and out_valid hold stable.
  - On acceptance of beat 32/DW-1: frame_done=1 for that following cycle, beat_cnt←0, go to LOAD. in_ready=1 in the very next cycle.
- in_ready=0 throughout WAIT and SEND; there is no overlap of frames.
- Latency: from the clock edge accepting the last input beat to the first out_valid=1 cycle is CORE_LAT+2 cycles. Throughput is one frame per NB + CORE_LAT + 1 + 32/DW cycles, minimum.
- Reset mid-operation (any state) aborts the frame:
  - The partial frame is discarded and the registers are cleared.
  - out_valid drops in the cycle after rst is sampled high.
- in_valid asserted during WAIT or SEND is ignored; the beat is not consumed.
- ciphertext is sampled only at the end of WAIT. Changes on it in any other state have no effect.
- Counter widths: beat_cnt is $clog2(NB) bits; wait_cnt is $clog2(CORE_LAT+1)+1 bits. No wrap-around is reachable, because each counter is cleared at its terminal count.
- Illegal DW, i.e. 32 % DW != 0: elaboration error.

Decomposition:
- Package simon_io_pkg holds:
  - the state enum (LOAD, WAIT, SEND);
  - constants SIMON_BLK_W=32 and SIMON_KEY_W=64;
  - a function computing NB from DW.
- No sub-module: one FSM plus datapath registers.
- simon_serial_io is instantiated inside the pad-ring top, between the pad cells and simon_for.

Test Plan:
- Known-answer test, DW=8, CORE_LAT=1, simon_for attached, out_ready=1:
  - Stimulus: beats 00,01,08,09,10,11,18,19,77,68,65,65.
  - keytext=64'h1918111009080100, plaintext=32'h65656877.
  - out beats bb,e9,9b,c6 (ciphertext 32'hc69be9bb); first out_valid exactly 3 cycles after the last input accept; frame_done pulses once.
- Input bubbles: same frame with in_valid deasserted every other cycle -> identical keytext/plaintext/output; beat_cnt advances only on accepts.
- Output backpressure: out_ready low for 5 cycles on beat 2 -> out_data holds 8'h9b stable with out_valid=1; no beat lost or duplicated.
- Reset mid-LOAD (after 7 beats) and mid-SEND (after 1 beat) -> next cycle: out_valid=0, in_ready=1, plaintext=0, keytext=0; a following full frame yields the correct c69be9bb.
- Ignored input: in_valid=1 with junk data throughout WAIT/SEND -> in_ready=0, no register change; back-to-back frames both produce correct ciphertext.
- Parameter sweep: DW∈{1,4,16}, CORE_LAT∈{0,3} -> NB = 96, 24, 6 respectively; latency is CORE_LAT+2; ciphertext matches the reference model for 100 random key/plaintext pairs.
